// File: rtl/iob_reg_arbiter.sv
// Round-robin arbiter feeding a single registered output slot.
// The winner is the first valid requester at or above the rotating pointer.
module iob_reg_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    cke_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    m_valid_o,
  output logic [ADDR_W-1:0]       m_addr_o,
  output logic [DATA_W-1:0]       m_data_o,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] m_id_o,
  input  logic                    m_ready_i
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic            can_load, load, win_found;
  logic [ID_W-1:0] win_idx;
  logic [ID_W:0]   cand;

  // Rotating search: candidate = (ptr + i) mod N_REQ, first valid wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!win_found && req_valid_i[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Reset gates the strobe so no handshake can complete while held.
  assign can_load = cke_i & ((state_q == ST_EMPTY) | m_ready_i);
  assign load     = arst_i & can_load & win_found;

  always_comb begin
    req_ready_o = '0;
    if (load) req_ready_o[win_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    id_d    = id_q;
    if (load) begin
      state_d = ST_FULL;
      addr_d  = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
      data_d  = req_data_i[int'(win_idx)*DATA_W +: DATA_W];
      id_d    = win_idx;
      ptr_d   = (win_idx == ID_W'(N_REQ-1)) ? '0 : win_idx + ID_W'(1);
    end else if (cke_i && state_q == ST_FULL && m_ready_i) begin
      // Drain keeps the last payload visible; only valid drops.
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign m_valid_o = (state_q == ST_FULL);
  assign m_addr_o  = addr_q;
  assign m_data_o  = data_q;
  assign m_id_o    = id_q;

endmodule

// File: tb/tb_iob_reg_arbiter.sv
// Bench for iob_reg_arbiter: directed table, hand sequences, random vs model.
module tb_iob_reg_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            cke;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            m_valid;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic [IW-1:0]   m_id;
  logic            m_ready;

  iob_reg_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .arst_i(arst_n), .cke_i(cke),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready), .m_valid_o(m_valid), .m_addr_o(m_addr),
    .m_data_o(m_data), .m_id_o(m_id), .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one slot plus an integer priority pointer.
  bit            mdl_full;
  int            mdl_ptr;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_data;
  int            mdl_id;
  logic [N-1:0]  last_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    if (!cke || (mdl_full && !m_ready)) return -1;
    for (int off = 0; off < N; off++)
      if (req_valid[(mdl_ptr + off) % N]) return (mdl_ptr + off) % N;
    return -1;
  endfunction

  task automatic mdl_reset();
    mdl_full = 0; mdl_ptr = 0; mdl_addr = '0; mdl_data = '0; mdl_id = 0;
  endtask

  // Called at posedge+1 with inputs set; ends at the next posedge+1.
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    #1;
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    last_ready = req_ready;
    chk("req_ready", req_ready, er);
    @(posedge clk);
    if (cke) begin
      if (g >= 0) begin
        mdl_full = 1;
        mdl_addr = req_addr[g*AW +: AW];
        mdl_data = req_data[g*DW +: DW];
        mdl_id   = g;
        mdl_ptr  = (g + 1) % N;
      end else if (mdl_full && m_ready) begin
        mdl_full = 0;
      end
    end
    #1;
    chk("m_valid", m_valid, mdl_full);
    chk("m_addr", m_addr, mdl_addr);
    chk("m_data", m_data, mdl_data);
    chk("m_id", m_id, mdl_id);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    mdl_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_data", m_data, 0);
    chk("rst_id", m_id, 0);
    chk("rst_ready", req_ready, 0);
    arst_n = 1'b1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic          mrdy;
    logic [N-1:0]  exp_ready;
    logic          exp_valid;
    logic [IW-1:0] exp_id;
  } vec_t;

  vec_t tbl[5];

  initial begin
    cke = 1'b1; req_valid = '0; m_ready = 1'b0; arst_n = 1'b1;
    req_addr = '0; req_data = '0;
    for (int k = 0; k < N; k++) set_req(k, AW'(16'h1000 + k), DW'(32'hA0000000 + k));
    #1;

    // All requesters valid, sink always ready: strict rotation.
    tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_valid = tbl[i].valid; m_ready = tbl[i].mrdy;
      cycle();
      chk("tbl_ready", last_ready, tbl[i].exp_ready);
      chk("tbl_valid", m_valid, tbl[i].exp_valid);
      chk("tbl_id", m_id, tbl[i].exp_id);
    end

    // Single requester held by a stalled sink.
    do_reset();
    set_req(2, 16'h00A5, 32'hDEADBEEF);
    req_valid = 4'b0100; m_ready = 1'b0;
    cycle();
    chk("hold_first_ready", last_ready, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_ready", last_ready, 4'b0000);
      chk("hold_addr", m_addr, 16'h00A5);
      chk("hold_data", m_data, 32'hDEADBEEF);
      chk("hold_id", m_id, 2);
    end
    req_valid = 4'b0000; m_ready = 1'b1;
    cycle();
    chk("drain_valid", m_valid, 0);
    chk("drain_keep_addr", m_addr, 16'h00A5);

    // Back-to-back: load while draining.
    req_valid = 4'b0100; m_ready = 1'b0;
    cycle();
    req_valid = 4'b0010; m_ready = 1'b1;
    cycle();
    chk("b2b_ready", last_ready, 4'b0010);
    chk("b2b_valid", m_valid, 1);
    chk("b2b_id", m_id, 1);

    // Pointer wrap after a grant to the top requester.
    do_reset();
    req_valid = 4'b1000; m_ready = 1'b1;
    cycle();
    chk("wrap_g3", m_id, 3);
    req_valid = 4'b1001;
    cycle();
    chk("wrap_g0", m_id, 0);
    cycle();
    chk("wrap_g3b", m_id, 3);

    // Clock-enable freeze with a pending drain.
    req_valid = 4'b0000; cke = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0110;
      cycle();
      chk("cke_ready", last_ready, 0);
      chk("cke_valid", m_valid, 1);
      chk("cke_id", m_id, 3);
    end
    cke = 1'b1; req_valid = 4'b0000;
    cycle();
    chk("cke_drain", m_valid, 0);

    // Asynchronous reset in the middle of a full slot.
    req_valid = 4'b0001; m_ready = 1'b0;
    cycle();
    req_valid = 4'b1111; m_ready = 1'b1;
    #3;
    arst_n = 1'b0;
    #1;
    chk("async_valid", m_valid, 0);
    chk("async_ready", req_ready, 0);
    mdl_reset();
    @(posedge clk); #1;
    chk("async_hold_valid", m_valid, 0);
    arst_n = 1'b1;
    req_valid = 4'b1010;
    cycle();
    chk("post_rst_ready", last_ready, 4'b0010);
    chk("post_rst_id", m_id, 1);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      m_ready   = ($urandom_range(0, 9) < 7);
      cke       = ($urandom_range(0, 9) < 9);
      for (int k = 0; k < N; k++) set_req(k, AW'($urandom), $urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
